// File: rtl/acc_control_unit.sv
// acc_control_unit: fetch/decode/execute/memory control FSM for the accumulator datapath
// Optional feature: define SINGLE_STEP_EN to add the step input and the STEP_WAIT state.
module acc_control_unit #(
  parameter int DATA_WIDTH   = 11,
  parameter int OPCODE_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] instr_in,
  input  logic                  acc_zero,
  input  logic                  mem_ready,
`ifdef SINGLE_STEP_EN
  input  logic                  step,
`endif
  output logic                  ir_wr,
  output logic                  pc_wr,
  output logic                  pc_src,
  output logic                  pc_reset,
  output logic                  acc_wr,
  output logic                  acc_reset,
  output logic [1:0]            acc_src,
  output logic                  alu_op,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic                  addr_sel,
  output logic                  halted,
  output logic                  illegal
);
  typedef enum logic [2:0] {S_INIT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT, S_STEP} state_t;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDA = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_STA = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_JZ  = OPCODE_WIDTH'(7);
  localparam logic [OPCODE_WIDTH-1:0] OP_CLR = OPCODE_WIDTH'(8);
  localparam logic [OPCODE_WIDTH-1:0] OP_HLT = OPCODE_WIDTH'(15);
`ifdef SINGLE_STEP_EN
  localparam state_t RESUME = S_STEP;
`else
  localparam state_t RESUME = S_FETCH;
`endif
  state_t state_q, state_d;
  logic illegal_q, illegal_d;
  logic [OPCODE_WIDTH-1:0] op;
  logic init, fetch, exec, mem, rd_op, mem_op, bad_op;
  logic unused_operand;
  assign op = instr_in[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign unused_operand = ^instr_in[DATA_WIDTH-OPCODE_WIDTH-1:0];
  assign init = state_q == S_INIT;
  assign fetch = state_q == S_FETCH;
  assign exec = state_q == S_EXEC;
  assign mem = state_q == S_MEM;
  assign rd_op = (op == OP_LDA) | (op == OP_ADD) | (op == OP_SUB);
  assign mem_op = rd_op | (op == OP_STA);
  assign bad_op = (op > OP_CLR) & (op != OP_HLT);
  // state and sticky illegal flag; reset wins over any pending handshake
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_INIT;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      illegal_q <= illegal_d;
    end
  end
  // next-state sequencing through the instruction phases
  always_comb begin
    state_d = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        state_d = (op == OP_HLT) ? S_HALT : mem_op ? S_MEM : RESUME;
        illegal_d = illegal_q | bad_op;
      end
      S_MEM:    state_d = mem_ready ? RESUME : S_MEM;
`ifdef SINGLE_STEP_EN
      S_STEP:   state_d = step ? S_FETCH : S_STEP;
`endif
      default:  state_d = state_q;
    endcase
  end
  // strobes and mux selects decoded from state, opcode and handshake
  always_comb begin
    ir_wr = fetch & mem_ready;
    pc_wr = (fetch & mem_ready) | (exec & ((op == OP_JMP) | ((op == OP_JZ) & acc_zero)));
    pc_src = exec & ((op == OP_JMP) | (op == OP_JZ));
    pc_reset = init;
    acc_wr = (exec & (op == OP_LDI)) | (mem & mem_ready & rd_op);
    acc_reset = init | (exec & (op == OP_CLR));
    acc_src = (exec & (op == OP_LDI)) ? 2'b10 : (mem & mem_ready & (op == OP_LDA)) ? 2'b01 : 2'b00;
    alu_op = mem & mem_ready & (op == OP_SUB);
    mem_rd = fetch | (mem & rd_op);
    mem_wr = mem & (op == OP_STA);
    addr_sel = mem;
    halted = state_q == S_HALT;
    illegal = illegal_q;
  end
endmodule

// File: tb/tb_acc_control_unit.sv
// tb_acc_control_unit: randomized scoreboard bench for acc_control_unit
module tb_acc_control_unit;
  localparam int IRW = 13, PCW = 12, PCS = 11, PCR = 10, ACW = 9, ACR = 8, SRC = 6;
  localparam int ALU = 5, RD = 4, WR = 3, AS = 2, HLTB = 1;
  typedef struct {logic [13:0] v; string t;} exp_t;
  logic clock = 0, reset = 0, acc_zero = 0, mem_ready = 0;
  logic [10:0] instr_in = '0;
  logic ir_wr, pc_wr, pc_src, pc_reset, acc_wr, acc_reset, alu_op, mem_rd, mem_wr, addr_sel, halted, illegal;
  logic [1:0] acc_src;
  logic ill = 0;
  int errors = 0, checks = 0;
  exp_t q[$];
`ifdef SINGLE_STEP_EN
  logic step = 0;
`endif
  acc_control_unit dut (
    .clock(clock), .reset(reset), .instr_in(instr_in), .acc_zero(acc_zero), .mem_ready(mem_ready),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_src(pc_src), .pc_reset(pc_reset), .acc_wr(acc_wr),
    .acc_reset(acc_reset), .acc_src(acc_src), .alu_op(alu_op), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .addr_sel(addr_sel), .halted(halted), .illegal(illegal)
  );
  always #5 clock = ~clock;
  function automatic logic [13:0] b(input int i);
    return 14'(1) << i;
  endfunction
  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction
  // one clock cycle: drive inputs, record what the outputs must be during it
  task automatic cyc(input logic mr, input logic az, input logic [13:0] e, input string t);
    exp_t x;
    mem_ready = mr;
    acc_zero = az;
    x.v = e | 14'(ill);
    x.t = t;
    q.push_back(x);
    @(posedge clock);
    #1;
  endtask
  task automatic do_reset(input logic mr, input logic [13:0] cur, input string t);
    reset = 0;
    cyc(mr, rb(), cur, t);
    reset = 1;
    ill = 0;
    cyc(rb(), rb(), b(PCR) | b(ACR), "init");
  endtask
  task automatic resume();
`ifdef SINGLE_STEP_EN
    int n;
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) cyc(rb(), rb(), 14'(0), "step_wait");
    step = 1;
    cyc(rb(), rb(), 14'(0), "step");
    step = 0;
`endif
  endtask
  // one instruction as a trace of expected per-cycle output vectors
  task automatic run(input logic [10:0] ins, input int fw, input int mw, input logic az, input bit rm);
    logic [3:0] op;
    logic [13:0] e, w, d;
    op = ins[10:7];
    for (int i = 0; i < fw; i++) cyc(0, rb(), b(RD), "fetch_wait");
    cyc(1, rb(), b(IRW) | b(PCW) | b(RD), "fetch");
    instr_in = ins;
    cyc(rb(), rb(), 14'(0), "decode");
    case (op)
      5: e = b(ACW) | (14'(2) << SRC);
      6: e = b(PCW) | b(PCS);
      7: e = (az ? b(PCW) : 14'(0)) | b(PCS);
      8: e = b(ACR);
      default: e = 14'(0);
    endcase
    cyc(rb(), az, e, "exec");
    if (op >= 9 && op <= 14) ill = 1;
    if (op == 15) begin
      for (int i = 0; i < 3; i++) cyc(rb(), rb(), b(HLTB), "halt");
      do_reset(rb(), b(HLTB), "halt_rst");
    end else if (op >= 1 && op <= 4) begin
      w = b(AS) | (op == 2 ? b(WR) : b(RD));
      case (op)
        1: d = w | b(ACW) | (14'(1) << SRC);
        3: d = w | b(ACW);
        4: d = w | b(ACW) | b(ALU);
        default: d = w;
      endcase
      for (int i = 0; i < mw; i++) cyc(0, rb(), w, "mem_wait");
      if (rm) do_reset(0, w, "mid_mem_rst");
      else begin
        cyc(1, rb(), d, "mem");
        resume();
      end
    end else resume();
  endtask
  // monitor: every cycle the DUT presents a vector, compare with the oldest expectation
  initial forever begin
    exp_t x;
    logic [13:0] got;
    @(negedge clock);
    if (q.size() > 0) begin
      x = q.pop_front();
      got = {ir_wr, pc_wr, pc_src, pc_reset, acc_wr, acc_reset, acc_src, alu_op, mem_rd, mem_wr, addr_sel, halted, illegal};
      checks++;
      if (got !== x.v) begin
        errors++;
        $display("FAIL %s: got=%b expected=%b at %0t", x.t, got, x.v, $time);
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
  initial begin
    @(posedge clock);
    #1;
    cyc(0, 0, b(PCR) | b(ACR), "rst_hold");
    reset = 1;
    cyc(0, 0, b(PCR) | b(ACR), "init");
    run(11'b01010000101, 0, 0, 0, 0);
    run(11'b00110000011, 1, 2, 0, 0);
    run(11'b01110001010, 0, 0, 1, 0);
    run(11'b01110001010, 2, 0, 0, 0);
    run(11'b00100000111, 0, 1, 1, 0);
    run(11'b01000000001, 0, 0, 0, 0);
    run(11'b00010000010, 0, 1, 0, 0);
    run(11'b10110000000, 0, 0, 0, 0);
    run(11'b01100000011, 1, 0, 0, 0);
    run(11'b10000000000, 0, 0, 1, 0);
    run(11'b11110000000, 0, 0, 0, 0);
    run(11'b00100000111, 0, 1, 0, 1);
    run(11'b01010000101, 0, 0, 0, 0);
    for (int k = 0; k < 300; k++)
      run(11'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), rb(), $urandom_range(0, 19) == 0);
    @(negedge clock);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/acc_control_unit.md
Name: acc_control_unit

Overview:
- Multi-cycle control FSM for the accumulator datapath.
- Sequences the accumulator register, the PC and IR registers, the ALU and the external memory through fetch/decode/execute/memory phases.
- Drives the write-enable and reset strobes of each register instance and the datapath mux selects.
- Inputs are the IR output, the accumulator-zero flag and the memory ready handshake.

Parameters:
- DATA_WIDTH, 11, instruction/data word width.
- OPCODE_WIDTH, 4, opcode field = instr_in[DATA_WIDTH-1 -: OPCODE_WIDTH]; operand = the remaining low bits.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- instr_in  in  DATA_WIDTH  IR output (reg_out of IR).
- acc_zero  in  1  accumulator == 0.
- mem_ready  in  1  memory completes the current mem_rd/mem_wr this cycle.
- ir_wr  out  1  IR reg_wr.
- pc_wr  out  1  PC reg_wr.
- pc_src  out  1  0 = PC+1, 1 = operand.
- pc_reset  out  1  PC reg_reset.
- acc_wr  out  1  accumulator reg_wr.
- acc_reset  out  1  accumulator reg_reset.
- acc_src  out  2  00 = ALU result, 01 = memory data, 10 = zero-extended operand.
- alu_op  out  1  0 = add, 1 = subtract.
- mem_rd  out  1  memory read request.
- mem_wr  out  1  memory write request.
- addr_sel  out  1  memory address: 0 = PC, 1 = operand.
- halted  out  1  HALT state.
- illegal  out  1  sticky, undefined opcode decoded.

Behaviour:
- State register only; outputs decoded combinationally from state, opcode, mem_ready and acc_zero. Any output not listed for a state is 0.
- Opcodes: 0 NOP, 1 LDA, 2 STA, 3 ADD, 4 SUB, 5 LDI, 6 JMP, 7 JZ, 8 CLR, F HLT. Codes 9–E are illegal: executed as NOP and set illegal.
- Reset: reset=0 at a rising edge gives state=INIT and illegal=0. Reset overrides every state, including a pending memory handshake; mem_rd/mem_wr drop after that edge.
- INIT (1 cycle): acc_reset=1, pc_reset=1 -> FETCH.
- FETCH: mem_rd=1, addr_sel=0; hold while mem_ready=0. On mem_ready=1: ir_wr=1, pc_wr=1, pc_src=0 -> DECODE.
- DECODE (1 cycle): no strobes; instr_in now valid -> EXEC.
- EXEC (1 cycle):
  - LDI: acc_wr=1, acc_src=10.
  - CLR: acc_reset=1.
  - JMP: pc_wr=1, pc_src=1.
  - JZ: pc_wr=acc_zero, pc_src=1.
  - NOP/illegal: nothing; illegal set at this edge for illegal codes.
  - All of the above -> FETCH.
  - LDA/STA/ADD/SUB -> MEM.
  - HLT -> HALT.
- MEM: addr_sel=1; mem_rd=1 for LDA/ADD/SUB, mem_wr=1 for STA; hold while mem_ready=0. On mem_ready=1:
  - LDA: acc_wr=1, acc_src=01.
  - ADD: acc_wr=1, acc_src=00, alu_op=0.
  - SUB: acc_wr=1, acc_src=00, alu_op=1.
  - STA: nothing further.
  - All -> FETCH.
- HALT: halted=1, all strobes 0; leaves only via reset.
- Latency with mem_ready tied 1: register/jump instructions take 3 cycles (FETCH, DECODE, EXEC); memory instructions take 4.
- Each wait cycle adds 1 cycle to FETCH or MEM.
- mem_rd and mem_wr are never both 1. ir_wr and acc_wr are never both 1.
- A mem_ready pulse outside FETCH/MEM is ignored.
- PC wrap-around is the datapath's responsibility; the FSM does not check it.

Optional Feature:
- Macro SINGLE_STEP_EN.
- When defined:
  - Extra input step (1 bit).
  - Extra state STEP_WAIT: every transition that would enter FETCH from EXEC or MEM enters STEP_WAIT instead.
  - STEP_WAIT holds with all strobes 0 until step=1 is sampled, then goes to FETCH.
  - INIT still goes directly to FETCH. HLT is unaffected.
- When undefined: no step port, no STEP_WAIT; behaviour as above.

Test Plan:
- Reset: hold reset=0 for 2 cycles, release -> first cycle acc_reset=1, pc_reset=1; next cycle mem_rd=1, addr_sel=0; illegal=0, halted=0.
- LDI with mem_ready=1: instr_in=11'b01010000101 (LDI 5) -> 3-cycle sequence; EXEC cycle shows acc_wr=1, acc_src=10; next cycle mem_rd=1 (FETCH).
- ADD with memory wait: instr_in=11'b00110000011, mem_ready low 2 cycles in MEM -> mem_rd=1, addr_sel=1 for 3 cycles; acc_wr=1, acc_src=00, alu_op=0 only in the mem_ready cycle.
- Branches:
  - JZ 11'b01110001010 with acc_zero=1 -> EXEC pc_wr=1, pc_src=1.
  - With acc_zero=0 -> pc_wr=0.
  - STA 11'b00100000111 -> mem_wr=1, mem_rd=0 in MEM.
- Illegal and halt:
  - instr_in=11'b10110000000 (opcode B) -> illegal=1 after EXEC and stays 1 through further instructions.
  - HLT 11'b11110000000 -> halted=1 indefinitely.
  - reset=0 -> INIT, illegal=0, halted=0.
- Reset mid-MEM: STA with mem_ready=0, assert reset=0 -> after the edge mem_wr=0 and state=INIT; with SINGLE_STEP_EN, after LDI the FSM stays idle until step=1, then mem_rd=1 next cycle.
